mux2a1_cuatrobits_tx: RTL and testbench

// - TX-side lane interleaver. Merges two 4-bit lanes into one 4-bit stream with a valid flag.
// - Output word order strictly alternates: lane0, lane1, lane0, ...
// - This order matches the RX 1-to-2 demux, which toggles its lane select on every valid word.
// - Each lane has a small FIFO so the two upstream sources may be skewed in time.
// - Sits between the two TX lane sources and the TX serializer; one clock domain (clk_4f).
//

---
 rtl/mux2a1_cuatrobits_tx_if.sv | 26 ++
 rtl/mux2a1_cuatrobits_tx.sv | 110 +++++++++++
 tb/tb_mux2a1_cuatrobits_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mux2a1_cuatrobits_tx_if.sv
// Lane-side handshake and interleaved output bundle for the TX 2-to-1 lane interleaver.
// slave = the interleaver itself, master = the lane sources plus the serializer side.
interface mux2a1_cuatrobits_tx_if #(
    parameter int DATA_W = 4
);
    logic              valid_in0;
    logic [DATA_W-1:0] data_in0;
    logic              ready_in0;
    logic              valid_in1;
    logic [DATA_W-1:0] data_in1;
    logic              ready_in1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              sel_out;
    logic              overflow;

    modport slave (
        input  valid_in0, data_in0, valid_in1, data_in1,
        output ready_in0, ready_in1, data_out, valid_out, sel_out, overflow
    );

    modport master (
        output valid_in0, data_in0, valid_in1, data_in1,
        input  ready_in0, ready_in1, data_out, valid_out, sel_out, overflow
    );
endinterface

// File: rtl/mux2a1_cuatrobits_tx.sv
// TX lane interleaver: two per-lane FIFOs drained in strict lane0/lane1 alternation, 1-cycle latency.
// A push into a full FIFO is dropped and sets the sticky overflow flag; an empty selected lane stalls both.
module mux2a1_cuatrobits_tx #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_4f,
    input  logic                     reset,
    mux2a1_cuatrobits_tx_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [PW-1:0]     wr_ptr_q [2];
    logic [PW-1:0]     wr_ptr_d [2];
    logic [PW-1:0]     rd_ptr_q [2];
    logic [PW-1:0]     rd_ptr_d [2];
    logic [CW-1:0]     cnt_q    [2];
    logic [CW-1:0]     cnt_d    [2];

    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              sel_out_q, sel_out_d;
    logic              overflow_q, overflow_d;

    logic              vld  [2];
    logic [DATA_W-1:0] din  [2];
    logic              rdy  [2];
    logic              push [2];
    logic              pop  [2];
    logic              head_avail;

    always_comb begin
        vld[0]      = bus.valid_in0;
        vld[1]      = bus.valid_in1;
        din[0]      = bus.data_in0;
        din[1]      = bus.data_in1;
        head_avail  = (cnt_q[sel_q] != '0);
        overflow_d  = overflow_q;
        sel_d       = sel_q;
        data_out_d  = data_out_q;
        sel_out_d   = sel_out_q;
        valid_out_d = 1'b0;

        for (int n = 0; n < 2; n++) begin
            // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
            rdy[n]      = (cnt_q[n] < FULL);
            push[n]     = vld[n] & rdy[n];
            pop[n]      = head_avail & (sel_q == 1'(n));
            if (vld[n] & ~rdy[n]) begin
                overflow_d = 1'b1;
            end
            wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + 1'b1 : wr_ptr_q[n];
            rd_ptr_d[n] = pop[n]  ? rd_ptr_q[n] + 1'b1 : rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
        end

        if (head_avail) begin
            data_out_d  = mem_q[sel_q][rd_ptr_q[sel_q]];
            valid_out_d = 1'b1;
            sel_out_d   = sel_q;
            sel_d       = ~sel_q;
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            sel_q       <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sel_out_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sel_out_q   <= sel_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk_4f) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= din[n];
            end
        end
    end

    assign bus.ready_in0 = rdy[0];
    assign bus.ready_in1 = rdy[1];
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.sel_out   = sel_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mux2a1_cuatrobits_tx.sv
// Directed bench for the TX lane interleaver: reset, alternation, stall, full/overflow, streaming, mid-run reset.
module tb_mux2a1_cuatrobits_tx;
    logic clk_4f = 1'b0;
    logic reset  = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    mux2a1_cuatrobits_tx_if #(.DATA_W(4)) bus ();

    mux2a1_cuatrobits_tx #(.DATA_W(4), .DEPTH(4)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic idle_in();
        bus.valid_in0 = 1'b0;
        bus.valid_in1 = 1'b0;
        bus.data_in0  = '0;
        bus.data_in1  = '0;
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1);
        bus.valid_in0 = v0;
        bus.data_in0  = d0;
        bus.valid_in1 = v1;
        bus.data_in1  = d1;
    endtask

    task automatic do_reset();
        @(negedge clk_4f);
        reset = 1'b1;
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    task automatic exp_word(input string tag, input logic [3:0] d, input logic s);
        chk({tag, "_vld"}, 32'(bus.valid_out), 32'd1);
        chk({tag, "_dat"}, 32'(bus.data_out), 32'(d));
        chk({tag, "_sel"}, 32'(bus.sel_out), 32'(s));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_vld"}, 32'(bus.valid_out), 32'd0);
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] w;
    logic       exp_sel;
    int         n_out;

    initial begin
        idle_in();
        #1 reset = 1'b1;
        #1;
        chk("rst_dat", 32'(bus.data_out), 32'd0);
        chk("rst_vld", 32'(bus.valid_out), 32'd0);
        chk("rst_sel", 32'(bus.sel_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_rdy0", 32'(bus.ready_in0), 32'd1);
        chk("rst_rdy1", 32'(bus.ready_in1), 32'd1);
        @(negedge clk_4f);
        reset = 1'b0;

        // Both lanes pushed together: lane0 first, then lane1, then idle with held data.
        drive(1, 4'h3, 1, 4'h5); tick(); exp_idle("t2_e0");
        idle_in();               tick(); exp_word("t2_w0", 4'h3, 1'b0);
        tick();                  exp_word("t2_w1", 4'h5, 1'b1);
        tick();                  exp_idle("t2_e3");
        chk("t2_hold_dat", 32'(bus.data_out), 32'h5);
        chk("t2_hold_sel", 32'(bus.sel_out), 32'd1);

        // Lane1 waits behind an empty lane0.
        drive(0, 4'h0, 1, 4'h7); tick(); exp_idle("t3_a");
        drive(0, 4'h0, 1, 4'h8); tick(); exp_idle("t3_b");
        idle_in();               tick(); exp_idle("t3_c");
        drive(1, 4'h1, 0, 4'h0); tick(); exp_idle("t3_d");
        idle_in();               tick(); exp_word("t3_w0", 4'h1, 1'b0);
        tick();                  exp_word("t3_w1", 4'h7, 1'b1);
        tick();                  exp_idle("t3_stall");
        chk("t3_stall_dat", 32'(bus.data_out), 32'h7);
        drive(1, 4'h2, 0, 4'h0); tick(); exp_idle("t3_e");
        idle_in();               tick(); exp_word("t3_w2", 4'h2, 1'b0);
        tick();                  exp_word("t3_w3", 4'h8, 1'b1);
        tick();                  exp_idle("t3_end");

        // Fill lane0 while lane1 is empty; sixth push lands on a full FIFO.
        drive(1, 4'hA, 0, 4'h0); tick(); exp_idle("t4_e1");
        drive(1, 4'hB, 0, 4'h0); tick(); exp_word("t4_wA", 4'hA, 1'b0);
        drive(1, 4'hC, 0, 4'h0); tick(); exp_idle("t4_e3");
        drive(1, 4'hD, 0, 4'h0); tick(); exp_idle("t4_e4");
        chk("t4_rdy0_3", 32'(bus.ready_in0), 32'd1);
        drive(1, 4'hE, 0, 4'h0); tick(); exp_idle("t4_e5");
        chk("t4_rdy0_full", 32'(bus.ready_in0), 32'd0);
        chk("t4_rdy1", 32'(bus.ready_in1), 32'd1);
        chk("t4_ovf0", 32'(bus.overflow), 32'd0);
        drive(1, 4'hF, 0, 4'h0); tick(); exp_idle("t4_e6");
        chk("t4_ovf1", 32'(bus.overflow), 32'd1);
        drive(0, 4'h0, 1, 4'h1); tick(); exp_idle("t4_e7");
        drive(0, 4'h0, 1, 4'h2); tick(); exp_word("t4_w1", 4'h1, 1'b1);
        // Lane0 is full while it pops this edge: 0x6 must be dropped.
        drive(1, 4'h6, 1, 4'h3); tick(); exp_word("t4_wB", 4'hB, 1'b0);
        chk("t4_rdy0_after", 32'(bus.ready_in0), 32'd1);
        idle_in();               tick(); exp_word("t4_w2", 4'h2, 1'b1);
        tick();                  exp_word("t4_wC", 4'hC, 1'b0);
        tick();                  exp_word("t4_w3", 4'h3, 1'b1);
        tick();                  exp_word("t4_wD", 4'hD, 1'b0);
        tick();                  exp_idle("t4_e14");
        drive(0, 4'h0, 1, 4'h4); tick(); exp_idle("t4_e15");
        idle_in();               tick(); exp_word("t4_w4", 4'h4, 1'b1);
        tick();                  exp_word("t4_wE", 4'hE, 1'b0);
        tick();                  exp_idle("t4_drop6");
        chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset clears the sticky flag before streaming.
        do_reset();
        chk("t5_ovf_clr", 32'(bus.overflow), 32'd0);

        // Both lanes at one word per two cycles, 200 words each.
        exp_sel = 1'b0;
        n_out   = 0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400 && (c % 2) == 0) begin
                drive(1, 4'(c / 2), 1, ~4'(c / 2 + 3));
                exp_q.push_back(4'(c / 2));
                exp_q.push_back(~4'(c / 2 + 3));
            end else begin
                idle_in();
            end
            tick();
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("t5_extra", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("t5_dat", 32'(bus.data_out), 32'(w));
                    chk("t5_sel", 32'(bus.sel_out), 32'(exp_sel));
                    exp_sel = ~exp_sel;
                    n_out++;
                end
            end
        end
        chk("t5_count", 32'(n_out), 32'd400);
        chk("t5_ovf", 32'(bus.overflow), 32'd0);

        // Build up three words per lane, then reset between clock edges.
        for (int k = 0; k < 5; k++) begin
            drive(1, 4'(k + 1), 1, 4'(k + 8));
            tick();
        end
        idle_in();
        chk("t6_pre_vld", 32'(bus.valid_out), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_vld", 32'(bus.valid_out), 32'd0);
        chk("t6_rst_dat", 32'(bus.data_out), 32'd0);
        chk("t6_rst_sel", 32'(bus.sel_out), 32'd0);
        chk("t6_rst_rdy0", 32'(bus.ready_in0), 32'd1);
        chk("t6_rst_rdy1", 32'(bus.ready_in1), 32'd1);
        @(negedge clk_4f);
        reset = 1'b0;
        drive(1, 4'h9, 0, 4'h0); tick(); exp_idle("t6_e0");
        idle_in();               tick(); exp_word("t6_w9", 4'h9, 1'b0);
        tick();                  exp_idle("t6_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
